sync_fifo_param: RTL

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Purpose : single-clock parameterised FIFO with occupancy flags, level thresholds and error pulses.
// Latency : FWFT=0 -> dout loads one edge after an accepted read; FWFT=1 -> head word visible the cycle after it is written.
// Backpres: writes are dropped while full (overflow pulse), reads are ignored while empty (underflow pulse).
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   din, we             write data / write request
//   re                  read request (FWFT=0) or read acknowledge (FWFT=1)
//   dout                read data
//   full, empty         occupancy flags derived from the registered count
//   almost_full         count >= AF_LEVEL
//   almost_empty        count <= AE_LEVEL
//   count               number of stored words (0..DEPTH)
//   overflow, underflow one-cycle pulses for a rejected write / read
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       we,
    input  logic                       re,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage is deliberately not reset; only the pointers and count define validity.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // All flags come straight from the registered count, so they are glitch-free.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // In first-word-fall-through mode the head entry is read combinationally
    // from storage; zero is shown while empty so the output never floats X.
    assign dout = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : dout_q;

    always_comb begin
        wr_acc      = we && !full;
        rd_acc      = re && !empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = we && full;
        underflow_d = re && empty;

        // Power-of-two depth: natural pointer wrap gives modulo DEPTH.
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end

        // Simultaneous accepted read and write leaves the count unchanged.
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Reset takes priority: a write presented during reset is not stored.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule
